// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Round-robin arbiter sharing one SDRAM controller request port between
// NUM_PORTS clients. One transaction in flight at a time: IDLE picks a
// pending port and latches its command, CMD holds it until the controller
// completes, DONE drops the grant and advances the round-robin pointer.
// All outputs are registered.
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to add a CMD-state watchdog
// of TIMEOUT_CYCLES cycles that completes the transaction with error_o set.

module sdram_port_arbiter #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned BE_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  // Client side
  input  logic [NUM_PORTS-1:0]          req_wr_i,
  input  logic [NUM_PORTS-1:0]          req_rd_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data_i,
  input  logic [NUM_PORTS*BE_W-1:0]     req_byte_en_i,
  output logic [NUM_PORTS-1:0]          ready_o,
  output logic [DATA_W-1:0]             q_o,
  output logic [NUM_PORTS-1:0]          grant_o,
  output logic                          busy_o,
  // Controller side
  input  logic                          ctl_available_i,
  output logic                          ctl_wr_o,
  output logic                          ctl_rd_o,
  output logic [ADDR_W-1:0]             ctl_addr_o,
  output logic [DATA_W-1:0]             ctl_data_o,
  output logic [BE_W-1:0]               ctl_byte_en_o,
  input  logic                          ctl_ready_i,
  input  logic [DATA_W-1:0]             ctl_q_i,
  output logic                          error_o
);

  localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [NUM_PORTS-1:0] ready_q, ready_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [DATA_W-1:0]    q_q, q_d;
  logic                 busy_q, busy_d;
  logic                 ctl_wr_q, ctl_wr_d;
  logic                 ctl_rd_q, ctl_rd_d;
  logic [ADDR_W-1:0]    ctl_addr_q, ctl_addr_d;
  logic [DATA_W-1:0]    ctl_data_q, ctl_data_d;
  logic [BE_W-1:0]      ctl_be_q, ctl_be_d;

  logic [NUM_PORTS-1:0] pending;
  logic                 pick_valid;
  logic [PtrW-1:0]      pick_idx;
  logic                 start;
  logic                 timeout_hit;

  logic [ADDR_W-1:0]    port_addr [NUM_PORTS];
  logic [DATA_W-1:0]    port_data [NUM_PORTS];
  logic [BE_W-1:0]      port_be   [NUM_PORTS];

  // Split the packed per-port buses into arrays indexed by port number.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign port_addr[p] = req_addr_i[p*ADDR_W +: ADDR_W];
    assign port_data[p] = req_data_i[p*DATA_W +: DATA_W];
    assign port_be[p]   = req_byte_en_i[p*BE_W +: BE_W];
  end

  // Write wins when a port raises both request lines.
  assign pending = req_wr_i | req_rd_i;

  // First pending port scanning upward from the round-robin pointer.
  always_comb begin
    int unsigned idx;
    logic [PtrW-1:0] idx_w;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_w      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx   = (32'(rr_ptr_q) + i) % NUM_PORTS;
      idx_w = PtrW'(idx);
      if (!pick_valid && pending[idx_w]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_w;
      end
    end
  end

  assign start = (state_q == StIdle) && pick_valid && ctl_available_i;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic            error_q;

  // Controller completion on the same cycle as the limit takes precedence.
  assign timeout_hit = (state_q == StCmd) && !ctl_ready_i &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: idles at zero outside CMD so every CMD entry starts fresh.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (state_q != StCmd) begin
      cnt_q <= '0;
    end else if (!timeout_hit) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Error flag pulses alongside the ready pulse of a timed-out transaction.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_q <= 1'b0;
    end else begin
      error_q <= timeout_hit;
    end
  end

  assign error_o = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StCmd;
      StCmd:  if (ctl_ready_i || timeout_hit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and arbitration bookkeeping.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    ready_d    = '0;
    grant_d    = grant_q;
    q_d        = q_q;
    ctl_wr_d   = ctl_wr_q;
    ctl_rd_d   = ctl_rd_q;
    ctl_addr_d = ctl_addr_q;
    ctl_data_d = ctl_data_q;
    ctl_be_d   = ctl_be_q;
    busy_d     = (state_d != StIdle);
    case (state_q)
      StIdle: begin
        if (start) begin
          gnt_idx_d          = pick_idx;
          grant_d            = '0;
          grant_d[pick_idx]  = 1'b1;
          ctl_addr_d         = port_addr[pick_idx];
          ctl_data_d         = port_data[pick_idx];
          ctl_be_d           = port_be[pick_idx];
          ctl_wr_d           = req_wr_i[pick_idx];
          ctl_rd_d           = ~req_wr_i[pick_idx];
        end
      end
      StCmd: begin
        if (ctl_ready_i || timeout_hit) begin
          ctl_wr_d           = 1'b0;
          ctl_rd_d           = 1'b0;
          ready_d[gnt_idx_q] = 1'b1;
          // Only a real read completion updates q; writes and timeouts keep it.
          if (ctl_ready_i && ctl_rd_q) begin
            q_d = ctl_q_i;
          end
        end
      end
      StDone: begin
        grant_d  = '0;
        rr_ptr_d = (gnt_idx_q == PtrW'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + PtrW'(1);
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      ready_q    <= '0;
      grant_q    <= '0;
      q_q        <= '0;
      busy_q     <= 1'b0;
      ctl_wr_q   <= 1'b0;
      ctl_rd_q   <= 1'b0;
      ctl_addr_q <= '0;
      ctl_data_q <= '0;
      ctl_be_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      ready_q    <= ready_d;
      grant_q    <= grant_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
      ctl_wr_q   <= ctl_wr_d;
      ctl_rd_q   <= ctl_rd_d;
      ctl_addr_q <= ctl_addr_d;
      ctl_data_q <= ctl_data_d;
      ctl_be_q   <= ctl_be_d;
    end
  end

  assign ready_o       = ready_q;
  assign q_o           = q_q;
  assign grant_o       = grant_q;
  assign busy_o        = busy_q;
  assign ctl_wr_o      = ctl_wr_q;
  assign ctl_rd_o      = ctl_rd_q;
  assign ctl_addr_o    = ctl_addr_q;
  assign ctl_data_o    = ctl_data_q;
  assign ctl_byte_en_o = ctl_be_q;

endmodule
